// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator pipeline.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_I       = 3'd1,
    FMT_I_SHAMT = 3'd2,
    FMT_S       = 3'd3,
    FMT_B       = 3'd4,
    FMT_U       = 3'd5,
    FMT_J       = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM_W  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fields are sized for the widest legal XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [63:0] imm;
    fmt_t        fmt;
    logic [63:0] tgt;
    logic        tgt_vld;
    logic [63:0] pc;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational format classifier, immediate extender and PC-relative adder.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output imm_res_t        res
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] imm;
  logic [63:0] pc_ext;
  logic [63:0] sum;
  fmt_t        fmt;
  logic        tgt_vld;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign pc_ext = 64'(pc);
  assign sum    = pc_ext + imm;

  // Classify the opcode and build the 64-bit sign/zero-extended immediate.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    tgt_vld = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt = FMT_I_SHAMT;
          imm = RV64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
        end else begin
          fmt = FMT_I;
          imm = {{52{instr[31]}}, instr[31:20]};
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt = FMT_I;
        imm = {{52{instr[31]}}, instr[31:20]};
      end
      OP_IMM_W: begin
        if (RV64) begin
          fmt = FMT_I_SHAMT;
          imm = {59'b0, instr[24:20]};
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        tgt_vld = 1'b1;
        imm     = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt     = FMT_U;
        tgt_vld = (opcode == OP_AUIPC);
        imm     = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt     = FMT_J;
        tgt_vld = 1'b1;
        imm     = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt = FMT_NONE;
      end
    endcase
  end

  // Pack the result; the target is forced to zero when it carries no meaning.
  always_comb begin
    res         = '0;
    res.imm     = imm;
    res.fmt     = fmt;
    res.tgt_vld = tgt_vld;
    res.tgt     = tgt_vld ? sum : 64'b0;
    res.pc      = pc_ext;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main output stage and one skid entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_tgt,
  output logic            out_tgt_vld,
  output logic [XLEN-1:0] out_pc
);

  imm_res_t dec_res;
  imm_res_t main_q;
  imm_res_t skid_q;
  logic     main_vld;
  logic     skid_vld;
  logic     ready_q;
  logic     accept;
  logic     drain;
  logic     main_free;
  logic     main_vld_n;
  logic     skid_vld_n;
  logic     load_main_in;
  logic     load_main_skid;
  logic     load_skid;

  imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .res   (dec_res)
  );

  assign accept    = in_valid & ready_q;
  assign drain     = main_vld & out_ready;
  assign main_free = ~main_vld | drain;

  // Decide where an accepted entry lands and how the two valid bits evolve.
  always_comb begin
    main_vld_n     = main_vld;
    skid_vld_n     = skid_vld;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        load_main_skid = 1'b1;
        main_vld_n     = 1'b1;
        skid_vld_n     = 1'b0;
      end else begin
        load_main_in = accept;
        main_vld_n   = accept;
      end
    end else if (accept) begin
      load_skid  = 1'b1;
      skid_vld_n = 1'b1;
    end
  end

  // Valid bits and the registered ready, which is low only while the skid is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      ready_q  <= ~skid_vld_n;
    end
  end

  // Data registers change only when an entry is loaded, so idle outputs stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= dec_res;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_res;
      end
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_tgt     = main_q.tgt[XLEN-1:0];
  assign out_tgt_vld = main_q.tgt_vld;
  assign out_pc      = main_q.pc[XLEN-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: queue-based reference model plus directed literal cases.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        vld;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_tgt;
  logic        out_tgt_vld;
  logic [31:0] out_pc;

  logic        flush_w;
  logic        in_valid_w;
  logic        in_ready_w;
  logic [31:0] in_instr_w;
  logic [63:0] in_pc_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [63:0] out_imm_w;
  logic [2:0]  out_fmt_w;
  logic [63:0] out_tgt_w;
  logic        out_tgt_vld_w;
  logic [63:0] out_pc_w;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] out_log[$];
  bit zero_data = 1'b1;
  bit last_accept;

  imm_gen_pipe #(.XLEN(32), .RV64(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_tgt(out_tgt), .out_tgt_vld(out_tgt_vld), .out_pc(out_pc)
  );

  imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush_w),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w), .in_pc(in_pc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_imm(out_imm_w), .out_fmt(out_fmt_w),
    .out_tgt(out_tgt_w), .out_tgt_vld(out_tgt_vld_w), .out_pc(out_pc_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Reference decode written directly from the field layouts using integer arithmetic.
  function automatic exp_t model_fn(input logic [31:0] instr, input logic [63:0] pc,
                                    input bit rv64, input int xlen);
    exp_t e;
    longint v = 0;
    logic [63:0] mask;
    logic [6:0] opc = instr[6:0];
    logic [2:0] f3 = instr[14:12];
    e.fmt = 3'd0;
    e.vld = 1'b0;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (opc)
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'd2;
          v = rv64 ? longint'(instr[25:20]) : longint'(instr[24:20]);
        end else begin
          e.fmt = 3'd1;
          v = longint'(instr[31:20]);
          if (v >= 2048) v -= 4096;
        end
      end
      7'h03, 7'h67, 7'h73: begin
        e.fmt = 3'd1;
        v = longint'(instr[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h1B: begin
        if (rv64) begin
          e.fmt = 3'd2;
          v = longint'(instr[24:20]);
        end
      end
      7'h23: begin
        e.fmt = 3'd3;
        v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        e.fmt = 3'd4;
        e.vld = 1'b1;
        v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
          + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd5;
        e.vld = (opc == 7'h17);
        v = longint'(instr[31:12]) * 4096;
        if (instr[31]) v -= (longint'(1) <<< 32);
      end
      7'h6F: begin
        e.fmt = 3'd6;
        e.vld = 1'b1;
        v = longint'(instr[31]) * (longint'(1) <<< 20) + longint'(instr[19:12]) * 4096
          + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
        if (v >= (longint'(1) <<< 20)) v -= (longint'(1) <<< 21);
      end
      default: v = 0;
    endcase
    e.imm = 64'(v) & mask;
    e.tgt = e.vld ? ((pc + e.imm) & mask) : 64'b0;
    e.pc  = pc & mask;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare every visible output of the 32-bit instance against the model state.
  task automatic check_output();
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_imm", 64'(out_imm), q[0].imm);
      check("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
      check("out_tgt", 64'(out_tgt), q[0].tgt);
      check("out_tgt_vld", 64'(out_tgt_vld), 64'(q[0].vld));
      check("out_pc", 64'(out_pc), q[0].pc);
    end else if (zero_data) begin
      check("idle_zero", {out_imm, out_tgt}, 64'b0);
      check("idle_zero_misc", {out_pc, 29'b0, out_fmt}, 64'b0);
    end
  endtask

  // Advance one clock, update the model from the driven inputs, then check.
  task automatic apply_stimulus();
    bit m_ready;
    if (out_valid && out_ready) out_log.push_back(out_pc);
    @(posedge clk);
    last_accept = 1'b0;
    if (rst) begin
      q.delete();
      zero_data = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      m_ready = (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && m_ready) begin
        q.push_back(model_fn(in_instr, {32'b0, in_pc}, 1'b0, 32));
        zero_data = 1'b0;
        last_accept = 1'b1;
      end
    end
    #1;
    check_output();
  endtask

  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    out_ready = 1'b1;
    apply_stimulus();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r = $urandom;
    int pick = $urandom_range(0, 11);
    logic [6:0] opc;
    if (pick >= 10) opc = 7'($urandom);
    else opc = ops[pick];
    return {r[31:7], opc};
  endfunction

  initial begin
    exp_t e;
    int idx;
    int guard;
    logic [31:0] bp_pc[4];
    logic [31:0] bp_in[4];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    flush_w = 1'b0; in_valid_w = 1'b0; in_instr_w = '0; in_pc_w = '0; out_ready_w = 1'b1;

    // Model pins against hand-computed values.
    e = model_fn(32'hFE000EE3, 64'h100, 1'b0, 32);
    check("pin_beq_imm", e.imm, 64'hFFFF_FFFC);
    check("pin_beq_tgt", e.tgt, 64'hFC);
    e = model_fn(32'h03F09093, 64'h0, 1'b1, 64);
    check("pin_slli64_imm", e.imm, 64'd63);
    e = model_fn(32'h800002B7, 64'h0, 1'b1, 64);
    check("pin_lui64_imm", e.imm, 64'hFFFF_FFFF_8000_0000);

    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;
    apply_stimulus();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_imm", 64'(out_imm), 64'd0);
    check("reset64_out_valid", 64'(out_valid_w), 64'd0);
    check("reset64_in_ready", 64'(in_ready_w), 64'd1);

    // Directed literal cases on the 32-bit instance.
    send_one(32'hFFF00093, 32'h0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    check("addi_fmt", 64'(out_fmt), 64'd1);
    check("addi_tgt_vld", 64'(out_tgt_vld), 64'd0);
    send_one(32'hFE000EE3, 32'h100);
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("beq_fmt", 64'(out_fmt), 64'd4);
    check("beq_tgt", 64'(out_tgt), 64'hFC);
    check("beq_tgt_vld", 64'(out_tgt_vld), 64'd1);
    send_one(32'hABCDE000, 32'h200);
    check("none_fmt", 64'(out_fmt), 64'd0);
    check("none_imm", 64'(out_imm), 64'd0);
    check("none_tgt_vld", 64'(out_tgt_vld), 64'd0);
    send_one(32'h008000EF, 32'hFFFF_FFFC);
    check("jal_wrap_tgt", 64'(out_tgt), 64'h4);
    check("jal_wrap_fmt", 64'(out_fmt), 64'd6);
    apply_stimulus();

    // 64-bit instance: LUI sign extension and RV64 six-bit shamt.
    in_valid_w = 1'b1; in_instr_w = 32'h800002B7; in_pc_w = 64'h10;
    @(posedge clk); #1;
    in_instr_w = 32'h03F09093; in_pc_w = 64'h14;
    check("lui64_valid", 64'(out_valid_w), 64'd1);
    check("lui64_imm", out_imm_w, 64'hFFFF_FFFF_8000_0000);
    check("lui64_fmt", 64'(out_fmt_w), 64'd5);
    check("lui64_tgt_vld", 64'(out_tgt_vld_w), 64'd0);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    e = model_fn(32'h03F09093, 64'h14, 1'b1, 64);
    check("slli64_imm", out_imm_w, 64'd63);
    check("slli64_fmt", 64'(out_fmt_w), 64'd2);
    check("slli64_model", out_imm_w, e.imm);
    q.delete();
    apply_stimulus();
    apply_stimulus();

    // Back-pressure: four offered instructions, consumer stalled for three cycles.
    for (int i = 0; i < 4; i++) begin
      bp_pc[i] = 32'h1000 + 32'(i * 4);
      bp_in[i] = {20'(i + 1), 12'h093};
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_instr = bp_in[idx]; in_pc = bp_pc[idx];
      apply_stimulus();
      if (last_accept) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_log.delete();
    out_ready = 1'b1;
    guard = 0;
    while ((idx < 4 || q.size() > 0) && guard < 20) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_instr = bp_in[idx]; in_pc = bp_pc[idx]; end
      apply_stimulus();
      if (last_accept) idx++;
      guard++;
    end
    in_valid = 1'b0;
    apply_stimulus();
    check("bp_drain_in_time", 64'(guard < 20), 64'd1);
    check("bp_out_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < out_log.size()) ? 64'(out_log[i]) : 64'hDEAD, 64'(bp_pc[i]));

    // Flush with both entries full and a new input offered the same cycle.
    out_ready = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 2 && guard < 10) begin
      in_valid = 1'b1; in_instr = bp_in[idx]; in_pc = 32'h2000 + 32'(idx * 4);
      apply_stimulus();
      if (last_accept) idx++;
      guard++;
    end
    check("flush_fill", 64'(idx), 64'd2);
    in_instr = 32'h0000_006F; in_pc = 32'h2008; flush = 1'b1;
    apply_stimulus();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    out_log.delete();
    for (int c = 0; c < 4; c++) apply_stimulus();
    check("flush_no_ghost", 64'(out_log.size()), 64'd0);

    // Mid-operation reset zeroes data registers.
    send_one(32'hFE000EE3, 32'h300);
    out_ready = 1'b0;
    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    apply_stimulus();
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_tgt", 64'(out_tgt), 64'd0);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | ((c % 97 == 0) ? 32'hFFFF_FF00 : 32'h0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      apply_stimulus();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    apply_stimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
